// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC stream producer.
package mac_pkg;

    function automatic int unsigned cap_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } pipe_ctl_t;

endpackage

// File: rtl/mac_stream_producer_if.sv
// Input pair stream plus write/capacity link to the downstream output FIFO.
interface mac_stream_producer_if #(
    parameter int unsigned INW   = 8,
    parameter int unsigned OUTW  = 16,
    parameter int unsigned DEPTH = 16
) ();

    logic signed [INW-1:0]                 IN_TDATA_X;
    logic signed [INW-1:0]                 IN_TDATA_W;
    logic                                  IN_TVALID;
    logic                                  IN_TREADY;
    logic [OUTW-1:0]                       data_out;
    logic                                  wr_en;
    logic [mac_pkg::cap_w(DEPTH)-1:0]      capacity;

    modport master (
        input  IN_TDATA_X, IN_TDATA_W, IN_TVALID, capacity,
        output IN_TREADY, data_out, wr_en
    );

    modport slave (
        output IN_TDATA_X, IN_TDATA_W, IN_TVALID, capacity,
        input  IN_TREADY, data_out, wr_en
    );

endinterface

// File: rtl/mac_pipe.sv
// Three-stage multiply-accumulate datapath: operand regs, product reg, accumulator/output regs.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int unsigned INW  = 8,
    parameter int unsigned OUTW = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_i,
    input  logic                   first_i,
    input  logic                   last_i,
    input  logic signed [INW-1:0]  x_i,
    input  logic signed [INW-1:0]  w_i,
    output logic [OUTW-1:0]        data_out_o,
    output logic                   wr_en_o
);

    pipe_ctl_t                 ctl0_q, ctl1_q;
    logic signed [INW-1:0]     x_q, w_q;
    logic signed [2*INW-1:0]   prod_q;
    logic [OUTW-1:0]           acc_q, acc_d;
    logic [OUTW-1:0]           data_out_q, data_out_d;
    logic                      wr_en_q, wr_en_d;
    logic [OUTW-1:0]           prod_ext;

    always_comb begin
        // Size cast of a signed product sign-extends or truncates to OUTW.
        prod_ext   = OUTW'(prod_q);
        acc_d      = acc_q;
        data_out_d = data_out_q;
        wr_en_d    = 1'b0;
        if (ctl1_q.valid) begin
            acc_d = ctl1_q.first ? prod_ext : acc_q + prod_ext;
            if (ctl1_q.last) begin
                data_out_d = acc_d;
                wr_en_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctl0_q     <= '0;
            ctl1_q     <= '0;
            x_q        <= '0;
            w_q        <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            ctl0_q <= '{valid: valid_i, first: first_i, last: last_i};
            ctl1_q <= ctl0_q;
            if (valid_i) begin
                x_q <= x_i;
                w_q <= w_i;
            end
            if (ctl0_q.valid) begin
                prod_q <= x_q * w_q;
            end
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign data_out_o = data_out_q;
    assign wr_en_o    = wr_en_q;

endmodule

// File: rtl/mac_stream_producer.sv
// Groups LEN products into one sum per FIFO write; input is throttled so a group's
// last pair is only taken when the FIFO has room for every result still in flight.
module mac_stream_producer
    import mac_pkg::*;
#(
    parameter int unsigned INW   = 8,
    parameter int unsigned OUTW  = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LEN   = 4
) (
    input logic                   clk,
    input logic                   reset_n,
    mac_stream_producer_if.master bus_io
);

    localparam int unsigned CntW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned CapW = cap_w(DEPTH);

    logic [CntW-1:0] elem_cnt_q, elem_cnt_d;
    logic [1:0]      pending_q, pending_d;
    logic [CapW:0]   cap_ext, pend_ext;
    logic            first, last, accept, in_tready;
    logic [OUTW-1:0] data_out;
    logic            wr_en;

    always_comb begin
        first     = (elem_cnt_q == '0);
        last      = (elem_cnt_q == CntW'(LEN - 1));
        cap_ext   = (CapW + 1)'(bus_io.capacity);
        pend_ext  = (CapW + 1)'(pending_q);
        // Only the last pair of a group consumes FIFO credit.
        in_tready = reset_n && (!last || (cap_ext > pend_ext));
        accept    = bus_io.IN_TVALID && in_tready;

        elem_cnt_d = elem_cnt_q;
        if (accept) begin
            elem_cnt_d = last ? '0 : elem_cnt_q + CntW'(1);
        end

        pending_d = pending_q;
        unique case ({accept && last, wr_en})
            2'b10:   pending_d = pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elem_cnt_q <= '0;
            pending_q  <= '0;
        end else begin
            elem_cnt_q <= elem_cnt_d;
            pending_q  <= pending_d;
        end
    end

    mac_pipe #(
        .INW  (INW),
        .OUTW (OUTW)
    ) u_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_i    (accept),
        .first_i    (first),
        .last_i     (last),
        .x_i        (bus_io.IN_TDATA_X),
        .w_i        (bus_io.IN_TDATA_W),
        .data_out_o (data_out),
        .wr_en_o    (wr_en)
    );

    assign bus_io.IN_TREADY = in_tready;
    assign bus_io.data_out  = data_out;
    assign bus_io.wr_en     = wr_en;

endmodule

// File: tb/tb_mac_stream_producer.sv
// Directed and random checks of mac_stream_producer against a group-sum model and a
// queue model of the downstream FIFO.
module tb_mac_stream_producer;
    import mac_pkg::*;

    localparam int unsigned INW    = 8;
    localparam int unsigned OUTW   = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LEN    = 4;
    localparam int unsigned DEPTH2 = 2;
    localparam int          GROUPS = 1500;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mac_stream_producer_if #(.INW(INW), .OUTW(OUTW), .DEPTH(DEPTH))  bus1 ();
    mac_stream_producer_if #(.INW(INW), .OUTW(OUTW), .DEPTH(DEPTH2)) bus2 ();

    mac_stream_producer #(.INW(INW), .OUTW(OUTW), .DEPTH(DEPTH), .LEN(LEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus1)
    );

    mac_stream_producer #(.INW(INW), .OUTW(OUTW), .DEPTH(DEPTH2), .LEN(1)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus2)
    );

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fifo_q[$];
    logic [15:0] ref_out_q[$];
    logic [15:0] p2_q[$];

    int n_cmp = 0, n_err = 0, cyc = 0;
    int cur_sum = 0, cur_n = 0, groups = 0;
    int cap_now = DEPTH, cap_val = 0, cap2 = DEPTH2;
    bit cap_force = 1'b0, axis_tready = 1'b1;
    int x_cur = 0, w_cur = 0;
    int wr_seen = 0, acc_seen = 0;
    logic [15:0] last_wr_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int x, input int w);
        x_cur = x;
        w_cur = w;
        bus1.IN_TVALID  = v;
        bus1.IN_TDATA_X = 8'(x);
        bus1.IN_TDATA_W = 8'(w);
    endtask

    task automatic drive_rand(input bit v);
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        drive(v, int'($signed(a)), int'($signed(b)));
    endtask

    task automatic apply_cap();
        cap_now = cap_force ? cap_val : int'(DEPTH) - fifo_q.size();
        bus1.capacity = 5'(cap_now);
    endtask

    // One clock of dut: check outputs at the falling edge, advance models after the rising edge.
    task automatic tick();
        bit          wr, exp_wr, exp_rdy, pop;
        logic [15:0] popped, wdata;
        @(negedge clk);
        exp_rdy = (cur_n != int'(LEN) - 1) || (cap_now > exp_q.size());
        check("in_tready", bus1.IN_TREADY, exp_rdy);
        wr     = bus1.wr_en;
        wdata  = bus1.data_out;
        exp_wr = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("wr_en", wr, exp_wr);
        if (wr) begin
            check("cap_on_wr", cap_now >= 1, 1);
            last_wr_data = wdata;
            wr_seen++;
        end
        if (exp_wr) begin
            if (wr) check("data_out", wdata, exp_q[0].val);
            void'(exp_q.pop_front());
        end
        if (bus1.IN_TVALID && bus1.IN_TREADY) begin
            acc_seen++;
            cur_sum += x_cur * w_cur;
            cur_n++;
            if (cur_n == int'(LEN)) begin
                // Accepted at this edge; visible after two more edges, seen at cyc+3.
                exp_q.push_back('{val: 16'(cur_sum), due: cyc + 3});
                ref_out_q.push_back(16'(cur_sum));
                cur_sum = 0;
                cur_n   = 0;
                groups++;
            end
        end
        pop = axis_tready && (fifo_q.size() > 0);
        @(posedge clk);
        #1;
        if (pop) begin
            popped = fifo_q.pop_front();
            if (ref_out_q.size() > 0) check("axis_data", popped, ref_out_q.pop_front());
            else check("axis_extra", 1, 0);
        end
        if (wr) fifo_q.push_back(wdata);
        apply_cap();
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit   w2;
        int   nw2, na2;
        logic [7:0] a, b;

        drive(0, 0, 0);
        apply_cap();
        bus2.IN_TVALID  = 1'b0;
        bus2.IN_TDATA_X = '0;
        bus2.IN_TDATA_W = '0;
        bus2.capacity   = 2'(cap2);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", bus1.IN_TREADY, 0);
        check("rst_wr_en", bus1.wr_en, 0);
        check("rst_data", bus1.data_out, 0);
        check("rst_tready2", bus2.IN_TREADY, 0);
        reset_n = 1'b1;

        // Basic group: 2 + 12 - 5 - 6 = 3
        wr_seen = 0;
        drive(1, 1, 2);  tick();
        drive(1, 3, 4);  tick();
        drive(1, -1, 5); tick();
        drive(1, 2, -3); tick();
        drive(0, 0, 0);
        repeat (5) tick();
        check("t1_pulses", wr_seen, 1);
        check("t1_data", last_wr_data, 16'd3);

        // Wraparound, no saturation
        wr_seen = 0;
        repeat (4) begin
            drive(1, 127, 127);
            tick();
        end
        drive(0, 0, 0);
        repeat (5) tick();
        check("t2_pulses", wr_seen, 1);
        check("t2_data", last_wr_data, 16'hFC04);

        // No credit: three pairs go in, the last waits for capacity
        cap_force = 1'b1;
        cap_val   = 0;
        apply_cap();
        acc_seen = 0;
        repeat (6) begin
            drive_rand(1);
            tick();
        end
        check("t3_stall_accepts", acc_seen, 3);
        cap_val = 1;
        apply_cap();
        wr_seen = 0;
        tick();
        check("t3_accepts", acc_seen, 4);
        drive(0, 0, 0);
        repeat (2) tick();
        check("t3_lat_early", wr_seen, 0);
        tick();
        check("t3_lat_pulse", wr_seen, 1);
        cap_force = 1'b0;
        apply_cap();
        repeat (4) tick();

        // Reset mid-group discards the partial sum
        drive(1, 7, 9);  tick();
        drive(1, -4, 6); tick();
        reset_n = 1'b0;
        #1;
        check("t5_rst_tready", bus1.IN_TREADY, 0);
        check("t5_rst_wr_en", bus1.wr_en, 0);
        check("t5_rst_data", bus1.data_out, 0);
        cur_sum = 0;
        cur_n   = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_seen = 0;
        drive(1, 3, -7);  tick();
        drive(1, 10, 10); tick();
        drive(1, -2, -2); tick();
        drive(1, 5, 1);   tick();
        drive(0, 0, 0);
        repeat (5) tick();
        check("t5_pulses", wr_seen, 1);
        check("t5_data", last_wr_data, 16'd88);

        // Random traffic and random FIFO drain
        groups = 0;
        while (groups < GROUPS && cyc < 40000) begin
            drive_rand(1'($urandom));
            axis_tready = 1'($urandom);
            tick();
        end
        check("t6_groups", groups >= GROUPS, 1);
        drive(0, 0, 0);
        axis_tready = 1'b1;
        repeat (40) tick();
        check("t6_exp_empty", exp_q.size(), 0);
        check("t6_fifo_empty", fifo_q.size(), 0);
        check("t6_ref_empty", ref_out_q.size(), 0);

        // LEN=1 into a 2-deep FIFO that is never read
        nw2 = 0;
        na2 = 0;
        bus2.IN_TVALID = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            bus2.IN_TDATA_X = a;
            bus2.IN_TDATA_W = b;
            @(negedge clk);
            w2 = bus2.wr_en;
            if (w2) begin
                nw2++;
                check("t4_cap_on_wr", cap2 >= 1, 1);
                if (p2_q.size() > 0) check("t4_data", bus2.data_out, p2_q.pop_front());
                else check("t4_extra_wr", 1, 0);
            end
            if (bus2.IN_TVALID && bus2.IN_TREADY) begin
                na2++;
                p2_q.push_back(16'(int'($signed(a)) * int'($signed(b))));
            end
            @(posedge clk);
            #1;
            if (w2) cap2--;
            bus2.capacity = 2'(cap2);
        end
        @(negedge clk);
        check("t4_writes", nw2, 2);
        check("t4_accepts", na2, 2);
        check("t4_tready", bus2.IN_TREADY, 0);
        check("t4_wr_idle", bus2.wr_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
